// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage.
// Op encodings, FSM states and datapath defaults.
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   localparam logic [3:0] ADD  = 4'd0;
   localparam logic [3:0] COMP = 4'd1;
   localparam logic [3:0] AND  = 4'd2;
   localparam logic [3:0] XOR  = 4'd3;
   localparam logic [3:0] SLL  = 4'd4;
   localparam logic [3:0] SRL  = 4'd5;
   localparam logic [3:0] SRA  = 4'd6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic op_is_shift(input logic [3:0] op);
      return (op == SLL) || (op == SRL) || (op == SRA);
   endfunction

endpackage

// File: rtl/alu_exec_stage_shifter.sv
// Iterative one-bit-per-cycle shifter used by the ALU execute stage.
// nxt/sout show the value and bit produced by the step taken at the next edge.
module serial_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dir,
   input  logic             arith,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   amt,
   output logic [WIDTH-1:0] nxt,
   output logic             sout,
   output logic             done
);

   logic [WIDTH-1:0] shreg;
   logic [SHW-1:0]   cnt;
   logic             dir_q;
   logic             arith_q;

   // dir_q=1 shifts right; arith_q sign-fills on right shifts
   always_comb begin
      nxt  = shreg;
      sout = 1'b0;
      if (dir_q) begin
         nxt  = {arith_q & shreg[WIDTH-1], shreg[WIDTH-1:1]};
         sout = shreg[0];
      end else begin
         nxt  = {shreg[WIDTH-2:0], 1'b0};
         sout = shreg[WIDTH-1];
      end
   end

   assign done = (cnt == SHW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         cnt     <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         shreg   <= din;
         cnt     <= amt;
         dir_q   <= dir;
         arith_q <= arith;
      end else if (cnt != '0) begin
         shreg <= nxt;
         cnt   <= cnt - SHW'(1);
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle arith/logic, iterative shifts.
// Registered result and flags behind a valid/ready handshake.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             illegal,
   output logic             busy
);

   state_t state_q;
   state_t state_d;

   logic             accept;
   logic             go_shift;
   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] c_res;
   logic             c_cy;
   logic             c_ill;
   logic [WIDTH-1:0] sh_nxt;
   logic             sh_sout;
   logic             sh_done;
   logic             sh_fin;

   assign amt      = inp2[SHW-1:0];
   assign in_ready = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign go_shift = accept && op_is_shift(alu_op) &&
                     (amt != '0);
   assign sh_fin   = (state_q == SHIFT) && sh_done;
   assign sum      = {1'b0, inp1} + {1'b0, inp2};

   // Shift ops only reach this path with amount 0
   always_comb begin
      c_res = '0;
      c_cy  = 1'b0;
      c_ill = 1'b0;
      unique case (1'b1)
         (alu_op == ADD):          {c_cy, c_res} = sum;
         (alu_op == COMP):         c_res = ~inp2 + WIDTH'(1);
         (alu_op == AND):          c_res = inp1 & inp2;
         (alu_op == XOR):          c_res = inp1 ^ inp2;
         op_is_shift(alu_op):      c_res = inp1;
         default:                  c_ill = 1'b1;
      endcase
   end

   serial_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .load  (go_shift),
      .dir   (alu_op != SLL),
      .arith (alu_op == SRA),
      .din   (inp1),
      .amt   (amt),
      .nxt   (sh_nxt),
      .sout  (sh_sout),
      .done  (sh_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if ((state_q == DONE) && !out_ready)
               state_d = DONE;
            else if (accept)
               state_d = go_shift ? SHIFT : DONE;
            else
               state_d = IDLE;
         end
         SHIFT: begin
            if (sh_done) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         sign    <= 1'b0;
         illegal <= 1'b0;
      end else if (accept && !go_shift) begin
         result  <= c_res;
         carry   <= c_cy;
         zero    <= (c_res == '0);
         sign    <= c_res[WIDTH-1];
         illegal <= c_ill;
      end else if (sh_fin) begin
         result  <= sh_nxt;
         carry   <= sh_sout;
         zero    <= (sh_nxt == '0);
         sign    <= sh_nxt[WIDTH-1];
         illegal <= 1'b0;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + random bench for alu_exec_stage.
// Expected results queued at drive time, checked on out_valid.
module tb_alu_exec_stage;
   import alu_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         s;
      logic         il;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   alu_op = 4'd0;
   logic [W-1:0] inp1 = '0;
   logic [W-1:0] inp2 = '0;
   logic         in_ready, out_valid, carry, zero, sign, illegal, busy;
   logic [W-1:0] result;

   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   int   lq[$];

   alu_exec_stage #(.WIDTH(W), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .inp1      (inp1),
      .inp2      (inp2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .sign      (sign),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t e;
      int   k;
      e = '0;
      k = int'(b[4:0]);
      case (op)
         ADD:  {e.c, e.r} = {1'b0, a} + {1'b0, b};
         COMP: e.r = -b;
         AND:  e.r = a & b;
         XOR:  e.r = a ^ b;
         SLL: begin
            e.r = a << k;
            if (k != 0) e.c = a[W-k];
         end
         SRL: begin
            e.r = a >> k;
            if (k != 0) e.c = a[k-1];
         end
         SRA: begin
            e.r = $signed(a) >>> k;
            if (k != 0) e.c = a[k-1];
         end
         default: e.il = 1'b1;
      endcase
      e.z = (e.r == '0);
      e.s = e.r[W-1];
      return e;
   endfunction

   task automatic chk_pop(input string tag);
      exp_t e;
      chk({tag, "_sb"}, W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_result"}, result, e.r);
         chk({tag, "_carry"}, W'(carry), W'(e.c));
         chk({tag, "_zero"}, W'(zero), W'(e.z));
         chk({tag, "_sign"}, W'(sign), W'(e.s));
         chk({tag, "_illegal"}, W'(illegal), W'(e.il));
      end
   endtask

   // Drives one op from a mid-cycle point; returns #1 after the accept edge
   task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
      int n = 0;
      alu_op   = op;
      inp1     = a;
      inp2     = b;
      in_valid = 1'b1;
      sb.push_back(model(op, a, b));
      lq.push_back((op_is_shift(op) && b[4:0] != 5'd0) ?
                   int'(b[4:0]) : 0);
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int   lat = 0;
      int   el;
      logic ir_seen = 1'b0;
      while (!out_valid && lat < 64) begin
         ir_seen |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_valid"}, W'(out_valid), W'(1));
      el = (lq.size() != 0) ? lq.pop_front() : -1;
      chk({tag, "_latency"}, W'(lat), W'(el));
      if (el > 0) chk({tag, "_inready_shift"}, W'(ir_seen), W'(0));
      chk_pop(tag);
   endtask

   initial begin
      logic         stable;
      logic         ir_any;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      #12;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_result", result, W'(0));
      chk("rst_flags", W'({carry, zero, sign, illegal}), W'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;

      send(ADD, 32'hFFFF_FFFF, 32'd1);
      wait_out("add_wrap");
      @(posedge clk); #1;

      send(SRA, 32'h8000_0010, 32'd4);
      wait_out("sra4");
      @(posedge clk); #1;

      send(SLL, 32'd10, 32'd0);
      wait_out("sll0");
      @(posedge clk); #1;

      send(SLL, 32'hC000_0000, 32'd2);
      wait_out("sll2");
      @(posedge clk); #1;
      chk("idle_after_xfer", W'(busy), W'(0));

      // back-to-back AND then XOR with no bubble
      alu_op   = AND;
      inp1     = 32'h0000_F0F0;
      inp2     = 32'h0000_0FF0;
      in_valid = 1'b1;
      sb.push_back(model(AND, inp1, inp2));
      sb.push_back(model(XOR, inp1, inp2));
      @(posedge clk); #1;
      alu_op = XOR;
      chk("b2b_and_valid", W'(out_valid), W'(1));
      chk("b2b_ready", W'(in_ready), W'(1));
      chk_pop("b2b_and");
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_xor_valid", W'(out_valid), W'(1));
      chk_pop("b2b_xor");
      @(posedge clk); #1;
      chk("b2b_idle", W'(busy), W'(0));

      // backpressure holds result; a competing op must not enter
      out_ready = 1'b0;
      send(COMP, 32'd0, 32'd15);
      wait_out("comp");
      alu_op   = ADD;
      inp1     = 32'd1;
      inp2     = 32'd2;
      in_valid = 1'b1;
      stable   = 1'b1;
      ir_any   = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         stable &= out_valid && (result == 32'hFFFF_FFF1);
         ir_any |= in_ready;
      end
      in_valid = 1'b0;
      chk("bp_stable", W'(stable), W'(1));
      chk("bp_inready", W'(ir_any), W'(0));
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", W'(out_valid), W'(0));
      chk("bp_release_busy", W'(busy), W'(0));

      // reset asserted in the middle of a 20-bit shift
      send(SLL, 32'h1234_5678, 32'd20);
      void'(sb.pop_back());
      void'(lq.pop_back());
      repeat (5) @(posedge clk);
      #3;
      chk("pre_rst_busy", W'(busy), W'(1));
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", W'(out_valid), W'(0));
      chk("mid_rst_busy", W'(busy), W'(0));
      chk("mid_rst_result", result, W'(0));
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_valid", W'(out_valid), W'(0));
      chk("post_rst_busy", W'(busy), W'(0));

      send(4'd9, 32'h1234, 32'h5678);
      wait_out("illegal9");
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         rop = 4'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         send(rop, ra, rb);
         wait_out($sformatf("rnd%0d_op%0d", i, rop));
         @(posedge clk); #1;
      end

      chk("sb_drained", W'(sb.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
